// File: rtl/switch_allocator_pkg.sv
// switch_allocator_pkg: shared types and constants for the router switch allocator.
package switch_allocator_pkg;
    localparam int NUM_PORTS  = 7;
    localparam int PORT_IDX_W = $clog2(NUM_PORTS);
    localparam int COORD_W    = 4;
    typedef enum logic [PORT_IDX_W-1:0] {
        LOCAL = 3'd0, NORTH = 3'd1, EAST = 3'd2, SOUTH = 3'd3, WEST = 3'd4, UP = 3'd5, DOWN = 3'd6
    } port_t;
    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] z;
    } position_t;
    typedef enum logic {IDLE, LOCKED} alloc_state_t;
    function automatic logic [PORT_IDX_W-1:0] next_idx(input logic [PORT_IDX_W-1:0] i);
        return (i == PORT_IDX_W'(NUM_PORTS - 1)) ? '0 : i + 1'b1;
    endfunction
endpackage

// File: rtl/switch_allocator_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr.
module rr_arbiter #(
    parameter int N = 7,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx,
    output logic         any
);
    always_comb begin
        int j;
        j = 0;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        // Walk from farthest to nearest so the closest request to ptr is written last.
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N;
            if (req[j]) begin
                gnt = '0;
                gnt[j] = 1'b1;
                idx = W'(j);
                any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/switch_allocator.sv
// switch_allocator: per-output round-robin wormhole allocation for a 7-port 3D-mesh router.
// SA_LFSR_EN selects an 8-bit LFSR for rand_bit; otherwise an alternating toggle pattern.
module switch_allocator
    import switch_allocator_pkg::*;
`ifdef SA_LFSR_EN
#(
    parameter logic [7:0] LFSR_SEED = 8'hA5
)
`endif
(
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            in_valid,
    input  logic [NUM_PORTS-1:0]            in_head,
    input  logic [NUM_PORTS-1:0]            in_tail,
    input  logic [NUM_PORTS*PORT_IDX_W-1:0] in_outport,
    output logic [NUM_PORTS-1:0]            in_ready,
    input  logic [NUM_PORTS-1:0]            out_ready,
    output logic [NUM_PORTS-1:0]            out_valid,
    output logic [NUM_PORTS*PORT_IDX_W-1:0] out_sel,
    output logic [NUM_PORTS-1:0]            rand_bit
);
    localparam int N = NUM_PORTS;
    localparam int W = PORT_IDX_W;

    alloc_state_t state_q [N];
    alloc_state_t state_d [N];
    logic [W-1:0] owner_q [N];
    logic [W-1:0] owner_d [N];
    logic [W-1:0] ptr_q [N];
    logic [W-1:0] ptr_d [N];
    logic [W-1:0] arb_idx [N];
    logic [N-1:0] own_q [N];
    logic [N-1:0] own_d [N];
    logic [N-1:0] arb_gnt [N];
    logic [N-1:0] req [N];
    logic [N-1:0] arb_any;
    logic [N-1:0] busy;
    logic [N-1:0] xfer;

    // own_q is the one-hot twin of owner_q, kept so busy/in_ready need no decoders.
    always_comb begin
        busy = '0;
        in_ready = '0;
        out_valid = '0;
        out_sel = '0;
        xfer = '0;
        for (int o = 0; o < N; o++) begin
            busy = busy | own_q[o];
            in_ready = in_ready | (own_q[o] & {N{out_ready[o]}});
            out_valid[o] = (state_q[o] == LOCKED) & in_valid[owner_q[o]];
            out_sel[o*W +: W] = (state_q[o] == LOCKED) ? owner_q[o] : '0;
            xfer[o] = out_valid[o] & out_ready[o];
        end
    end

    always_comb begin
        for (int o = 0; o < N; o++) begin
            for (int i = 0; i < N; i++) begin
                req[o][i] = in_valid[i] & in_head[i] & ~busy[i] & (in_outport[i*W +: W] == W'(o));
            end
        end
    end

    for (genvar o = 0; o < N; o++) begin : g_arb
        rr_arbiter #(.N(N)) u_arb (
            .req (req[o]),
            .ptr (ptr_q[o]),
            .gnt (arb_gnt[o]),
            .idx (arb_idx[o]),
            .any (arb_any[o])
        );
    end

    // A tail transfer only releases; a waiting head is arbitrated in the following cycle.
    always_comb begin
        for (int o = 0; o < N; o++) begin
            state_d[o] = state_q[o];
            owner_d[o] = owner_q[o];
            own_d[o] = own_q[o];
            ptr_d[o] = ptr_q[o];
            if (state_q[o] == IDLE && arb_any[o]) begin
                state_d[o] = LOCKED;
                owner_d[o] = arb_idx[o];
                own_d[o] = arb_gnt[o];
            end else if (xfer[o] && in_tail[owner_q[o]]) begin
                state_d[o] = IDLE;
                own_d[o] = '0;
                ptr_d[o] = next_idx(owner_q[o]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int o = 0; o < N; o++) begin
                state_q[o] <= IDLE;
                owner_q[o] <= '0;
                own_q[o] <= '0;
                ptr_q[o] <= '0;
            end
        end else begin
            for (int o = 0; o < N; o++) begin
                state_q[o] <= state_d[o];
                owner_q[o] <= owner_d[o];
                own_q[o] <= own_d[o];
                ptr_q[o] <= ptr_d[o];
            end
        end
    end

`ifdef SA_LFSR_EN
    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        rand_bit = '0;
        for (int i = 0; i < N; i++) rand_bit[i] = lfsr_q[i % 8];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr_q <= LFSR_SEED;
        else lfsr_q <= lfsr_d;
    end
`else
    logic t_q;
    logic t_d;

    always_comb begin
        t_d = ~t_q;
        rand_bit = '0;
        for (int i = 0; i < N; i++) rand_bit[i] = t_q ^ 1'(i % 2);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) t_q <= 1'b0;
        else t_q <= t_d;
    end
`endif
endmodule

// File: tb/tb_switch_allocator.sv
// tb_switch_allocator: directed checks of allocation, round-robin order, backpressure and reset.
module tb_switch_allocator;
    import switch_allocator_pkg::*;
    localparam int N = NUM_PORTS;
    localparam int W = PORT_IDX_W;
`ifdef SA_LFSR_EN
    localparam logic [6:0] RAND0 = 7'h25;
    localparam logic [6:0] RAND1 = 7'h4A;
`else
    localparam logic [6:0] RAND0 = 7'h2A;
    localparam logic [6:0] RAND1 = 7'h55;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0] in_valid, in_head, in_tail, in_ready, out_ready, out_valid, rand_bit;
    logic [N*W-1:0] in_outport, out_sel;

    int errors = 0;
    int checks = 0;
    int rem [N];
    int len [N];
    bit auto_rl [N];
    int mon_o = 0;
    int mon_log [$];
    int last_xfers = 0;

    switch_allocator dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_head    (in_head),
        .in_tail    (in_tail),
        .in_outport (in_outport),
        .in_ready   (in_ready),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_sel    (out_sel),
        .rand_bit   (rand_bit)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            in_valid[i] = rem[i] > 0;
            in_head[i] = rem[i] > 0 && rem[i] == len[i];
            in_tail[i] = rem[i] == 1;
        end
    endtask

    task automatic launch(input int i, input int o, input int n);
        rem[i] = n;
        len[i] = n;
        in_outport[i*W +: W] = W'(o);
        drive();
    endtask

    task automatic clear_src();
        for (int i = 0; i < N; i++) begin
            rem[i] = 0;
            len[i] = 0;
            auto_rl[i] = 1'b0;
        end
        in_outport = '0;
        drive();
        #1;
    endtask

    // Sample mid-cycle, advance one clock, then update the source model.
    task automatic tick();
        logic [N-1:0] x;
        #3;
        x = in_valid & in_ready;
        last_xfers = $countones(x);
        if (out_valid[mon_o] && out_ready[mon_o]) mon_log.push_back(int'(out_sel[mon_o*W +: W]));
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (x[i]) begin
                rem[i]--;
                if (rem[i] == 0 && auto_rl[i]) rem[i] = len[i];
            end
        end
        drive();
        #1;
    endtask

    initial begin
        int c;
        int n1;
        int n4;
        int rep;
        int exp_cont [9] = '{2, 2, 2, 4, 4, 4, 6, 6, 6};
        out_ready = '1;
        clear_src();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_sel", 32'(out_sel), 0);
        rst = 1'b0;
        #1;
        chk("rand_0", 32'(rand_bit), 32'(RAND0));
        tick();
        chk("rand_1", 32'(rand_bit), 32'(RAND1));

        // Single-flit LOCAL -> NORTH
        launch(0, NORTH, 1);
        #1;
        chk("single_grant_cycle_ready", 32'(in_ready), 0);
        chk("single_grant_cycle_valid", 32'(out_valid), 0);
        tick();
        chk("single_out_valid", 32'(out_valid), 32'h02);
        chk("single_out_sel", 32'(out_sel[NORTH*W +: W]), LOCAL);
        chk("single_in_ready", 32'(in_ready), 32'h01);
        tick();
        chk("single_xfers", 32'(last_xfers), 1);
        chk("single_idle_valid", 32'(out_valid), 0);
        chk("single_idle_ready", 32'(in_ready), 0);

        // Out-of-range outport never requests
        launch(0, 7, 2);
        tick();
        tick();
        chk("bad_port_valid", 32'(out_valid), 0);
        chk("bad_port_ready", 32'(in_ready), 0);
        clear_src();

        // Contention on UP from EAST, WEST, DOWN
        mon_o = UP;
        mon_log.delete();
        launch(WEST, UP, 3);
        launch(EAST, UP, 3);
        launch(DOWN, UP, 3);
        for (c = 0; c < 40 && (rem[EAST] + rem[WEST] + rem[DOWN]) > 0; c++) tick();
        chk("cont_cycles", 32'(c), 12);
        chk("cont_count", 32'(mon_log.size()), 9);
        for (int k = 0; k < 9; k++)
            chk($sformatf("cont_order_%0d", k), 32'(k < mon_log.size() ? mon_log[k] : -1), 32'(exp_cont[k]));
        clear_src();

        // Backpressure on WEST, 4-flit packet from SOUTH
        mon_o = WEST;
        mon_log.delete();
        launch(SOUTH, WEST, 4);
        tick();
        tick();
        tick();
        chk("bp_sent_before", 32'(rem[SOUTH]), 2);
        out_ready[WEST] = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp_in_ready_%0d", k), 32'(in_ready[SOUTH]), 0);
            chk($sformatf("bp_hold_%0d", k), 32'({out_valid[WEST], out_sel[WEST*W +: W]}), 32'h0B);
            tick();
        end
        chk("bp_no_xfer", 32'(rem[SOUTH]), 2);
        out_ready = '1;
        for (c = 0; c < 10 && rem[SOUTH] > 0; c++) tick();
        chk("bp_resume_cycles", 32'(c), 2);
        chk("bp_count", 32'(mon_log.size()), 4);
        rep = 0;
        foreach (mon_log[k]) if (mon_log[k] != SOUTH) rep++;
        chk("bp_owner", 32'(rep), 0);
        chk("bp_released", 32'(out_valid), 0);
        clear_src();

        // All seven inputs to distinct outputs
        for (int i = 0; i < N; i++) launch(i, (i + 1) % N, 3);
        tick();
        chk("par_out_valid", 32'(out_valid), 32'h7F);
        chk("par_in_ready", 32'(in_ready), 32'h7F);
        for (int o = 0; o < N; o++)
            chk($sformatf("par_sel_%0d", o), 32'(out_sel[o*W +: W]), 32'((o + N - 1) % N));
        tick();
        chk("par_xfers_first", 32'(last_xfers), 7);
        tick();
        tick();
        chk("par_xfers_last", 32'(last_xfers), 7);
        chk("par_done", 32'(out_valid), 0);
        clear_src();

        // Fairness: NORTH and WEST continuously to SOUTH (SOUTH ptr is 3 after the parallel test)
        mon_o = SOUTH;
        mon_log.delete();
        auto_rl[NORTH] = 1'b1;
        auto_rl[WEST] = 1'b1;
        launch(NORTH, SOUTH, 1);
        launch(WEST, SOUTH, 1);
        for (c = 0; c < 400 && mon_log.size() < 100; c++) tick();
        chk("fair_count", 32'(mon_log.size()), 100);
        n1 = 0;
        n4 = 0;
        rep = 0;
        foreach (mon_log[k]) begin
            if (mon_log[k] == NORTH) n1++;
            if (mon_log[k] == WEST) n4++;
            if (k > 0 && mon_log[k] == mon_log[k-1]) rep++;
        end
        chk("fair_total", 32'(n1 + n4), 100);
        chk("fair_balance", 32'((n1 - n4) <= 1 && (n4 - n1) <= 1), 1);
        chk("fair_alternate", 32'(rep), 0);
        chk("fair_first", 32'(mon_log.size() > 0 ? mon_log[0] : -1), WEST);
        chk("fair_cycles", 32'(c), 200);
        clear_src();

        // Reset mid-packet on EAST
        launch(NORTH, EAST, 4);
        tick();
        tick();
        chk("mid_locked", 32'(out_valid[EAST]), 1);
        rst = 1'b1;
        #1;
        chk("mid_async_valid", 32'(out_valid), 0);
        chk("mid_async_ready", 32'(in_ready), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("mid_valid", 32'(out_valid), 0);
        chk("mid_ready", 32'(in_ready), 0);
        chk("mid_sel", 32'(out_sel), 0);
        chk("mid_rand", 32'(rand_bit), 32'(RAND0));
        tick();
        chk("mid_east_idle", 32'(out_valid[EAST]), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
